// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select encoding for the fetch-stage PC sequencer.
package pc_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'hBFC0_0380;
    localparam int unsigned INSTR_BYTES      = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR,
        SEL_EXC,
        SEL_ERET
    } pc_sel_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack (pointer + saturating count) used as a jr target hint.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_top,
    output logic             o_valid
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;

    logic             w_empty;
    logic             w_full;
    logic [PW-1:0]    w_ptr_inc;
    logic [PW-1:0]    w_ptr_dec;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(RAS_DEPTH));
    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push && i_pop && !w_empty) begin
            // jalr: pop then push collapses to overwriting the current top
            r_mem[r_ptr] <= i_data;
        end else if (i_push) begin
            // when full, the slot after ptr holds the oldest entry and is overwritten
            r_mem[w_ptr_inc] <= i_data;
            r_ptr            <= w_ptr_inc;
            if (!w_full) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (i_pop && !w_empty) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_top   = w_empty ? '0 : r_mem[r_ptr];
    assign o_valid = !w_empty;

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch-stage PC sequencer: prioritised next-PC selection, EPC register and RAS hint.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pc_en,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             link,
    input  logic             exception,
    input  logic [WIDTH-1:0] epc_in,
    input  logic             eret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_is_zero,
    output logic             pc_misaligned,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;

    pc_sel_t          w_sel;
    logic             w_load;
    logic [WIDTH-1:0] w_pc_next;
    logic             w_push;
    logic             w_pop;

    assign pc_plus4      = r_pc + WIDTH'(INSTR_BYTES);
    assign pc            = r_pc;
    assign epc           = r_epc;
    assign pc_is_zero    = (r_pc == '0);
    assign pc_misaligned = |r_pc[1:0];

    // exception and eret bypass the stall; every other source waits for pc_en
    always_comb begin
        w_sel  = SEL_SEQ;
        w_load = 1'b0;
        if (exception) begin
            w_sel  = SEL_EXC;
            w_load = 1'b1;
        end else if (eret) begin
            w_sel  = SEL_ERET;
            w_load = 1'b1;
        end else if (pc_en) begin
            w_load = 1'b1;
            if (jr) begin
                w_sel = SEL_JR;
            end else if (jump) begin
                w_sel = SEL_J;
            end else if (branch_taken) begin
                w_sel = SEL_BR;
            end
        end
    end

    always_comb begin
        w_pc_next = pc_plus4;
        case (w_sel)
            SEL_SEQ:  w_pc_next = pc_plus4;
            SEL_BR:   w_pc_next = branch_target;
            SEL_J:    w_pc_next = jump_target;
            SEL_JR:   w_pc_next = jr_target;
            SEL_EXC:  w_pc_next = EXC_PC;
            SEL_ERET: w_pc_next = r_epc;
            default:  w_pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= RST_PC;
            r_epc <= '0;
        end else begin
            if (w_load) begin
                r_pc <= w_pc_next;
            end
            if (exception) begin
                r_epc <= epc_in;
            end
        end
    end

    // an eret redirect leaves the stack alone, as does a trap other than clearing it
    assign w_push = link & pc_en & ~exception & ~eret;
    assign w_pop  = jr & pc_en & ~exception & ~eret;

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (exception),
        .i_data  (pc_plus4),
        .o_top   (ras_top),
        .o_valid (ras_valid)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        pc_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic        link;
    logic        exception;
    logic [31:0] epc_in;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_is_zero;
    logic        pc_misaligned;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic        ras_valid;

    int unsigned n_checks;
    int unsigned n_fail;

    pc_sequencer #(
        .WIDTH        (32),
        .RESET_VECTOR (32'hBFC0_0000),
        .EXC_VECTOR   (32'hBFC0_0380),
        .RAS_DEPTH    (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_en         (pc_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_target     (jr_target),
        .link          (link),
        .exception     (exception),
        .epc_in        (epc_in),
        .eret          (eret),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_is_zero    (pc_is_zero),
        .pc_misaligned (pc_misaligned),
        .epc           (epc),
        .ras_top       (ras_top),
        .ras_valid     (ras_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pc_en         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        jr            = 1'b0;
        jr_target     = '0;
        link          = 1'b0;
        exception     = 1'b0;
        epc_in        = '0;
        eret          = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset_n = 1'b1;
        step();
        step();

        // 1: asynchronous reset applied mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_pc", pc, 32'hBFC0_0000);
        check_eq("rst_epc", epc, 32'h0);
        check_eq("rst_ras_valid", {31'b0, ras_valid}, 32'h0);
        check_eq("rst_ras_top", ras_top, 32'h0);
        step();
        check_eq("rst_hold_pc", pc, 32'hBFC0_0000);
        reset_n = 1'b1;

        // 2: sequential then stall
        pc_en = 1'b1;
        step();
        step();
        step();
        check_eq("seq_pc", pc, 32'hBFC0_000C);
        check_eq("seq_pc_plus4", pc_plus4, 32'hBFC0_0010);
        pc_en = 1'b0;
        step();
        step();
        check_eq("stall_pc", pc, 32'hBFC0_000C);

        // 3: priority jr > jump > branch
        pc_en         = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h8000_0100;
        branch_taken  = 1'b1;
        branch_target = 32'h8000_0300;
        step();
        check_eq("prio_jump", pc, 32'h8000_0100);
        jr        = 1'b1;
        jr_target = 32'h8000_0200;
        step();
        check_eq("prio_jr", pc, 32'h8000_0200);
        check_eq("jr_empty_pop", {31'b0, ras_valid}, 32'h0);
        jr   = 1'b0;
        jump = 1'b0;
        step();
        check_eq("branch_pc", pc, 32'h8000_0300);
        branch_taken = 1'b0;
        link         = 1'b1;
        step();
        check_eq("link_pc", pc, 32'h8000_0304);
        check_eq("link_top", ras_top, 32'h8000_0304);
        check_eq("link_valid", {31'b0, ras_valid}, 32'h1);
        link = 1'b0;

        // 4: exception while stalled, then eret
        pc_en     = 1'b0;
        exception = 1'b1;
        epc_in    = 32'h8000_0040;
        step();
        check_eq("exc_pc", pc, 32'hBFC0_0380);
        check_eq("exc_epc", epc, 32'h8000_0040);
        check_eq("exc_ras_valid", {31'b0, ras_valid}, 32'h0);
        check_eq("exc_ras_top", ras_top, 32'h0);
        exception = 1'b0;
        epc_in    = 32'h0;
        eret      = 1'b1;
        step();
        check_eq("eret_pc", pc, 32'h8000_0040);
        check_eq("eret_epc", epc, 32'h8000_0040);
        eret = 1'b0;

        // 5: RAS overflow, drain, empty pop, jalr
        pc_en       = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h0000_0100;
        step();
        check_eq("ras_start_pc", pc, 32'h0000_0100);
        link = 1'b1;
        for (int unsigned k = 2; k <= 6; k++) begin
            jump_target = k << 8;
            step();
        end
        check_eq("ras_push_pc", pc, 32'h0000_0600);
        check_eq("ras_full_top", ras_top, 32'h0000_0504);
        link      = 1'b0;
        jump      = 1'b0;
        jr        = 1'b1;
        jr_target = 32'h0000_1000;
        step();
        check_eq("pop1_top", ras_top, 32'h0000_0404);
        step();
        check_eq("pop2_top", ras_top, 32'h0000_0304);
        step();
        check_eq("pop3_top", ras_top, 32'h0000_0204);
        check_eq("pop3_valid", {31'b0, ras_valid}, 32'h1);
        step();
        check_eq("pop4_valid", {31'b0, ras_valid}, 32'h0);
        check_eq("pop4_top", ras_top, 32'h0);
        step();
        check_eq("pop5_valid", {31'b0, ras_valid}, 32'h0);
        check_eq("pop5_pc", pc, 32'h0000_1000);
        link      = 1'b1;
        jr_target = 32'h0000_2000;
        step();
        check_eq("jalr_empty_top", ras_top, 32'h0000_1004);
        check_eq("jalr_empty_pc", pc, 32'h0000_2000);
        jr_target = 32'h0000_3000;
        step();
        check_eq("jalr_replace_top", ras_top, 32'h0000_2004);
        link      = 1'b0;
        jr_target = 32'h0000_4000;
        step();
        check_eq("jalr_count_kept", {31'b0, ras_valid}, 32'h0);
        jr    = 1'b0;
        pc_en = 1'b0;
        link  = 1'b1;
        step();
        check_eq("stall_no_push", {31'b0, ras_valid}, 32'h0);
        check_eq("stall_pc_hold", pc, 32'h0000_4000);
        link = 1'b0;

        // 6: wrap-around and misaligned target
        pc_en       = 1'b1;
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        check_eq("wrap_pc_hi", pc, 32'hFFFF_FFFC);
        check_eq("wrap_plus4", pc_plus4, 32'h0);
        jump = 1'b0;
        step();
        check_eq("wrap_pc", pc, 32'h0);
        check_eq("wrap_zero", {31'b0, pc_is_zero}, 32'h1);
        check_eq("wrap_aligned", {31'b0, pc_misaligned}, 32'h0);
        jump        = 1'b1;
        jump_target = 32'h0000_0102;
        step();
        check_eq("mis_pc", pc, 32'h0000_0102);
        check_eq("mis_flag", {31'b0, pc_misaligned}, 32'h1);
        check_eq("mis_not_zero", {31'b0, pc_is_zero}, 32'h0);
        idle_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
